instruction_fetch: RTL and testbench

//  Fetch stage directly upstream of control_matrix. Reads 24-bit commands from the

---
 rtl/instruction_fetch_pkg.sv | 37 +++
 rtl/instruction_fetch_if.sv | 31 +++
 rtl/instruction_fetch_fifo.sv | 67 ++++++
 rtl/instruction_fetch.sv | 99 +++++++++
 tb/tb_instruction_fetch.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// Definitions shared by the fetch stage and control_matrix: widths, command
// field positions, opcodes and the fetch FSM encoding.
package instruction_fetch_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int CMD_WIDTH  = 24;
    localparam int FIFO_DEPTH = 2;
    localparam logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0;

    localparam int OPCODE_MSB   = 23;
    localparam int OPCODE_LSB   = 18;
    localparam int OPERAND1_MSB = 17;
    localparam int OPERAND1_LSB = 9;
    localparam int OPERAND2_MSB = 8;
    localparam int OPERAND2_LSB = 0;

    typedef enum logic [5:0] {
        OP_ADD = 6'd1,
        OP_SUB = 6'd2,
        OP_INV = 6'd3,
        OP_MOV = 6'd4,
        OP_JFE = 6'd5,
        OP_JFL = 6'd6,
        OP_JFG = 6'd7
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2
    } fetch_state_e;

    function automatic opcode_e commandOpcode(input logic [CMD_WIDTH-1:0] command);
        return opcode_e'(command[OPCODE_MSB:OPCODE_LSB]);
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: ROM read port, command handshake towards control_matrix,
// jump redirect and the exported instruction pointer.
interface instruction_fetch_if #(
    parameter int ADDR_WIDTH = instruction_fetch_pkg::ADDR_WIDTH,
    parameter int CMD_WIDTH  = instruction_fetch_pkg::CMD_WIDTH
);

    logic                  fetchEnable;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic                  memReadEnable;
    logic [CMD_WIDTH-1:0]  memData;
    logic [CMD_WIDTH-1:0]  commandOut;
    logic [ADDR_WIDTH-1:0] commandPc;
    logic                  commandValid;
    logic                  commandReady;
    logic                  jumpValid;
    logic [ADDR_WIDTH-1:0] jumpTarget;
    logic [ADDR_WIDTH-1:0] instructionPointer;

    // The fetch stage is the master; ROM, consumer and jump source sit on the slave side.
    modport master (
        input  fetchEnable, memData, commandReady, jumpValid, jumpTarget,
        output memAddr, memReadEnable, commandOut, commandPc, commandValid, instructionPointer
    );

    modport slave (
        output fetchEnable, memData, commandReady, jumpValid, jumpTarget,
        input  memAddr, memReadEnable, commandOut, commandPc, commandValid, instructionPointer
    );

endinterface

// File: rtl/instruction_fetch_fifo.sv
// Small synchronous FIFO holding {pc, command} entries; flush overrides push and pop.
module instruction_fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        pushData_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        headData_o,
    output logic [$clog2(DEPTH):0]  occupancy_o,
    output logic                    empty_o
);

    localparam int PTR_WIDTH = $clog2(DEPTH);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [PTR_WIDTH-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
    logic [PTR_WIDTH:0]   count_q, count_d;
    logic                 full, doPush, doPop;

    assign empty_o     = (count_q == '0);
    assign full        = (count_q == (PTR_WIDTH+1)'(DEPTH));
    assign doPop       = pop_i && !empty_o;
    assign doPush      = push_i && (!full || doPop);
    assign headData_o  = mem_q[rdPtr_q];
    assign occupancy_o = count_q;

    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (flush_i) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) wrPtr_d = wrPtr_q + PTR_WIDTH'(1);
            if (doPop)  rdPtr_d = rdPtr_q + PTR_WIDTH'(1);
            case ({doPush, doPop})
                2'b10:   count_d = count_q + (PTR_WIDTH+1)'(1);
                2'b01:   count_d = count_q - (PTR_WIDTH+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until the count says so.
    always_ff @(posedge clock) begin
        if (doPush && !flush_i) mem_q[wrPtr_q] <= pushData_i;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: reads commands from the synchronous ROM, buffers them and hands
// them to control_matrix; jump redirects flush everything fetched beyond the jump.
module instruction_fetch #(
    parameter int ADDR_WIDTH = instruction_fetch_pkg::ADDR_WIDTH,
    parameter int CMD_WIDTH  = instruction_fetch_pkg::CMD_WIDTH,
    parameter int FIFO_DEPTH = instruction_fetch_pkg::FIFO_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = instruction_fetch_pkg::RESET_VECTOR
) (
    input logic                  clock,
    input logic                  reset,
    instruction_fetch_if.master  bus
);

    import instruction_fetch_pkg::*;

    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_WIDTH:0] DEPTH_LIMIT = (CNT_WIDTH+1)'(FIFO_DEPTH);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pointer_q, pointer_d;
    logic [ADDR_WIDTH-1:0] inFlightPc_q, inFlightPc_d;
    logic                  inFlight_q, inFlight_d;

    logic                            jumpTaken, pop, issue, fifoEmpty;
    logic [CNT_WIDTH-1:0]            occupancy;
    logic [ADDR_WIDTH+CMD_WIDTH-1:0] headEntry;
    logic [CNT_WIDTH:0]              demand, capacity;

    assign pop       = !fifoEmpty && bus.commandReady;
    assign jumpTaken = bus.jumpValid && (state_q != IDLE);

    // A read may only go out if its data is guaranteed a slot when it lands.
    assign demand   = {1'b0, occupancy} + {{CNT_WIDTH{1'b0}}, inFlight_q};
    assign capacity = DEPTH_LIMIT + {{CNT_WIDTH{1'b0}}, pop};

    always_comb begin
        state_d      = state_q;
        pointer_d    = pointer_q;
        inFlightPc_d = pointer_q;
        issue        = 1'b0;

        case (state_q)
            IDLE:     state_d = RUN;
            RUN:      if (bus.jumpValid) state_d = REDIRECT;
            REDIRECT: state_d = RUN;
            default:  state_d = IDLE;
        endcase

        if (state_q == RUN && bus.fetchEnable && !jumpTaken && demand < capacity) begin
            issue = 1'b1;
        end

        if (jumpTaken) begin
            pointer_d = bus.jumpTarget;
        end else if (issue) begin
            pointer_d = pointer_q + ADDR_WIDTH'(1);
        end

        inFlight_d = issue;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            pointer_q    <= RESET_VECTOR;
            inFlight_q   <= 1'b0;
            inFlightPc_q <= '0;
        end else begin
            state_q      <= state_d;
            pointer_q    <= pointer_d;
            inFlight_q   <= inFlight_d;
            inFlightPc_q <= inFlightPc_d;
        end
    end

    // A response landing on the jump edge is discarded by the flush.
    instruction_fetch_fifo #(
        .WIDTH (ADDR_WIDTH + CMD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .flush_i     (jumpTaken),
        .push_i      (inFlight_q),
        .pushData_i  ({inFlightPc_q, bus.memData}),
        .pop_i       (pop),
        .headData_o  (headEntry),
        .occupancy_o (occupancy),
        .empty_o     (fifoEmpty)
    );

    assign bus.memReadEnable      = issue;
    assign bus.memAddr            = issue ? pointer_q : '0;
    assign bus.instructionPointer = pointer_q;
    assign bus.commandValid       = !fifoEmpty;
    assign bus.commandOut         = fifoEmpty ? '0 : headEntry[CMD_WIDTH-1:0];
    assign bus.commandPc          = fifoEmpty ? '0 : headEntry[ADDR_WIDTH+CMD_WIDTH-1:CMD_WIDTH];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a ROM model answers reads, a monitor checks
// every accepted command against a queue of hand-derived {pc, command} values.
module tb_instruction_fetch;

    import instruction_fetch_pkg::*;

    logic clock;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    logic [ADDR_WIDTH+CMD_WIDTH-1:0] expectQ[$];
    logic [ADDR_WIDTH+CMD_WIDTH-1:0] gotEntry, wantEntry;

    instruction_fetch_if bus ();

    instruction_fetch dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [CMD_WIDTH-1:0] romWord(input logic [ADDR_WIDTH-1:0] addr);
        return 24'h040000 | {16'h0000, addr};
    endfunction

    // Synchronous ROM: data appears the cycle after the read strobe.
    always @(posedge clock) begin
        if (bus.memReadEnable === 1'b1) bus.memData <= romWord(bus.memAddr);
    end

    // Monitor: a command is consumed when valid&&ready and neither reset nor a jump cancels it.
    always @(negedge clock) begin
        if (reset === 1'b0 && bus.commandValid === 1'b1 && bus.commandReady === 1'b1
            && bus.jumpValid === 1'b0) begin
            gotEntry = {bus.commandPc, bus.commandOut};
            vectors++;
            if (expectQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL stream: unexpected command pc=%h cmd=%h, required none", bus.commandPc, bus.commandOut);
            end else begin
                wantEntry = expectQ.pop_front();
                if (gotEntry !== wantEntry) begin
                    miscompares++;
                    $display("[TB] FAIL stream: got pc=%h cmd=%h, required pc=%h cmd=%h",
                             gotEntry[31:24], gotEntry[23:0], wantEntry[31:24], wantEntry[23:0]);
                end
            end
        end
    end

    task automatic applyStimulus(input logic rst, input logic fe, input logic rdy,
                                 input logic jv, input logic [7:0] tgt);
        @(posedge clock);
        #1;
        reset            = rst;
        bus.fetchEnable  = fe;
        bus.commandReady = rdy;
        bus.jumpValid    = jv;
        bus.jumpTarget   = tgt;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic pushExpected(input logic [7:0] pc);
        expectQ.push_back({pc, romWord(pc)});
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, 32'(bus.commandValid), 32'd0);
        checkOutput({tag, "_cmd"},   32'(bus.commandOut), 32'd0);
        checkOutput({tag, "_pc"},    32'(bus.commandPc), 32'd0);
        checkOutput({tag, "_rd"},    32'(bus.memReadEnable), 32'd0);
        checkOutput({tag, "_addr"},  32'(bus.memAddr), 32'd0);
        checkOutput({tag, "_ip"},    32'(bus.instructionPointer), 32'd0);
    endtask

    initial begin
        #5000;
        $display("[TB] FAIL watchdog: still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset            = 1'b1;
        bus.fetchEnable  = 1'b1;
        bus.commandReady = 1'b0;
        bus.jumpValid    = 1'b0;
        bus.jumpTarget   = 8'h00;

        applyStimulus(1, 1, 0, 0, 8'h00);
        applyStimulus(1, 1, 0, 0, 8'h00);
        checkResetState("reset");

        // Streaming from reset with the consumer always ready.
        for (int i = 0; i < 8; i++) pushExpected(8'(i));
        applyStimulus(0, 1, 1, 0, 8'h00);
        checkOutput("idle_rd", 32'(bus.memReadEnable), 32'd0);
        applyStimulus(0, 1, 1, 0, 8'h00);
        checkOutput("first_rd", 32'(bus.memReadEnable), 32'd1);
        checkOutput("first_addr", 32'(bus.memAddr), 32'h00);
        applyStimulus(0, 1, 1, 0, 8'h00);
        checkOutput("lat_valid", 32'(bus.commandValid), 32'd0);
        checkOutput("second_addr", 32'(bus.memAddr), 32'h01);
        for (int j = 0; j < 8; j++) begin
            applyStimulus(0, 1, 1, 0, 8'h00);
            checkOutput("stream_valid", 32'(bus.commandValid), 32'd1);
            checkOutput("stream_pc", 32'(bus.commandPc), 32'(j));
        end

        // Back-pressure: reads stop once buffer plus in-flight fill the FIFO.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 1, 0, 0, 8'h00);
            checkOutput("stall_rd", 32'(bus.memReadEnable), 32'd0);
            checkOutput("stall_pc", 32'(bus.commandPc), 32'h08);
            checkOutput("stall_cmd", 32'(bus.commandOut), 32'(romWord(8'h08)));
        end
        for (int i = 8; i < 14; i++) pushExpected(8'(i));
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 1, 1, 0, 8'h00);
            checkOutput("release_pc", 32'(bus.commandPc), 32'(8 + k));
        end

        // Jump while the FIFO is full.
        applyStimulus(0, 1, 0, 0, 8'h00);
        applyStimulus(0, 1, 0, 0, 8'h00);
        checkOutput("full_pc", 32'(bus.commandPc), 32'h0E);
        applyStimulus(0, 1, 0, 1, 8'h40);
        checkOutput("jump_rd", 32'(bus.memReadEnable), 32'd0);
        for (int i = 8'h40; i < 8'h44; i++) pushExpected(8'(i));
        applyStimulus(0, 1, 1, 0, 8'h00);
        checkOutput("flush_valid", 32'(bus.commandValid), 32'd0);
        checkOutput("redirect_rd", 32'(bus.memReadEnable), 32'd0);
        checkOutput("jump_ip", 32'(bus.instructionPointer), 32'h40);
        applyStimulus(0, 1, 1, 0, 8'h00);
        checkOutput("target_rd", 32'(bus.memReadEnable), 32'd1);
        checkOutput("target_addr", 32'(bus.memAddr), 32'h40);
        applyStimulus(0, 1, 1, 0, 8'h00);
        checkOutput("target_wait", 32'(bus.commandValid), 32'd0);
        applyStimulus(0, 1, 1, 0, 8'h00);
        checkOutput("target_valid", 32'(bus.commandValid), 32'd1);
        checkOutput("target_pc", 32'(bus.commandPc), 32'h40);
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 1, 0, 8'h00);

        // Jump coincident with a pop and an in-flight response, target near wrap.
        applyStimulus(0, 1, 1, 1, 8'hFE);
        checkOutput("coinc_rd", 32'(bus.memReadEnable), 32'd0);
        checkOutput("coinc_pc", 32'(bus.commandPc), 32'h44);
        for (int i = 0; i < 5; i++) pushExpected(8'(8'hFE + i));
        applyStimulus(0, 1, 1, 0, 8'h00);
        checkOutput("coinc_valid", 32'(bus.commandValid), 32'd0);
        checkOutput("coinc_ip", 32'(bus.instructionPointer), 32'hFE);
        applyStimulus(0, 1, 1, 0, 8'h00);
        checkOutput("wrap_addr0", 32'(bus.memAddr), 32'hFE);
        checkOutput("wrap_ip", 32'(bus.instructionPointer), 32'hFE);
        applyStimulus(0, 1, 1, 0, 8'h00);
        checkOutput("wrap_addr1", 32'(bus.memAddr), 32'hFF);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1, 1, 0, 8'h00);
            checkOutput("wrap_pc", 32'(bus.commandPc), 32'(8'(8'hFE + k)));
        end

        // One-cycle reset mid-stream, then a fetchEnable gap.
        applyStimulus(1, 1, 1, 0, 8'h00);
        applyStimulus(0, 1, 1, 0, 8'h00);
        checkResetState("midrst");
        pushExpected(8'h00);
        pushExpected(8'h01);
        applyStimulus(0, 1, 1, 0, 8'h00);
        checkOutput("restart_rd", 32'(bus.memReadEnable), 32'd1);
        checkOutput("restart_addr", 32'(bus.memAddr), 32'h00);
        applyStimulus(0, 1, 1, 0, 8'h00);
        checkOutput("restart_addr1", 32'(bus.memAddr), 32'h01);
        applyStimulus(0, 0, 1, 0, 8'h00);
        checkOutput("fe_off_rd", 32'(bus.memReadEnable), 32'd0);
        checkOutput("fe_off_pc0", 32'(bus.commandPc), 32'h00);
        applyStimulus(0, 0, 1, 0, 8'h00);
        checkOutput("fe_off_pc1", 32'(bus.commandPc), 32'h01);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 1, 0, 8'h00);
            checkOutput("fe_off_valid", 32'(bus.commandValid), 32'd0);
            checkOutput("fe_off_rd2", 32'(bus.memReadEnable), 32'd0);
        end
        for (int i = 2; i < 6; i++) pushExpected(8'(i));
        applyStimulus(0, 1, 1, 0, 8'h00);
        checkOutput("resume_addr", 32'(bus.memAddr), 32'h02);
        applyStimulus(0, 1, 1, 0, 8'h00);
        checkOutput("resume_addr1", 32'(bus.memAddr), 32'h03);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, 1, 0, 8'h00);
            checkOutput("resume_pc", 32'(bus.commandPc), 32'(2 + k));
        end

        repeat (3) applyStimulus(0, 1, 0, 0, 8'h00);
        checkOutput("drain", 32'(expectQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
